// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: Digit access codes, FSM states
// and helpers that decode an access code into its byte size and legality.
package dm_pkg;

    localparam logic [2:0] DIG_W   = 3'b000;
    localparam logic [2:0] DIG_HS  = 3'b001;
    localparam logic [2:0] DIG_BS  = 3'b010;
    localparam logic [2:0] DIG_HU  = 3'b101;
    localparam logic [2:0] DIG_BU  = 3'b110;
    localparam logic [2:0] DIG_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [2:0] access_size(input logic [2:0] digit);
        logic [2:0] size;
        case (digit)
            DIG_W:          size = 3'd4;
            DIG_HS, DIG_HU: size = 3'd2;
            default:        size = 3'd1;
        endcase
        return size;
    endfunction

    function automatic logic digit_ok(input logic [2:0] digit);
        return (digit == DIG_W)  || (digit == DIG_HS) || (digit == DIG_BS) ||
               (digit == DIG_HU) || (digit == DIG_BU);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester port of the data-memory arbiter: valid/ready request plus a
// single-cycle response pulse. The requester is master, the arbiter is slave.
interface dm_arbiter_if #(
    parameter int AW = 9
);
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    digit;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, we, addr, wdata, digit,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, we, addr, wdata, digit,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way combinational arbiter, one-hot grant, zero latency; a lone request always
// wins, a tie goes to port 0 under fixed priority, else to the port not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two requesters onto the byte-addressed data memory: accept in N, memory
// access in N+1, response pulse in N+2; req_ready is held low outside IDLE.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int AW         = 9,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    dm_arbiter_if.slave   p0,
    dm_arbiter_if.slave   p1,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic [2:0]    dm_digit,
    input  logic [31:0]   dm_dout
);

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic [1:0]    req, grant;
    logic          take;

    logic          lat_port;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_digit;
    logic [31:0]   rdata_q;

    logic [AW:0]   end_addr;
    logic          acc_err;
    logic          is_half;

    assign req = {p1.req_valid, p0.req_valid};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant)
    );

    assign take = (state_q == IDLE) && (|req);

    // The latched request only changes on a grant, so the check is stable for the
    // whole access and the held dm_* pins stay consistent afterwards.
    assign is_half  = (lat_digit == DIG_HS) || (lat_digit == DIG_HU);
    assign end_addr = {1'b0, lat_addr} + {{(AW-2){1'b0}}, access_size(lat_digit)}
                      - (AW+1)'(1);
    assign acc_err  = !digit_ok(lat_digit)
                   || (lat_we && ((lat_digit == DIG_HU) || (lat_digit == DIG_BU)))
                   || ((lat_digit == DIG_W) && (lat_addr[1:0] != 2'b00))
                   || (is_half && lat_addr[0])
                   || end_addr[AW];

    assign dm_addr  = lat_addr;
    assign dm_din   = lat_wdata;
    assign dm_digit = acc_err ? DIG_NOP : lat_digit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_port     <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_digit    <= DIG_W;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_grant_q <= grant[1];
                lat_port     <= grant[1];
                lat_we       <= grant[1] ? p1.we    : p0.we;
                lat_addr     <= grant[1] ? p1.addr  : p0.addr;
                lat_wdata    <= grant[1] ? p1.wdata : p0.wdata;
                lat_digit    <= grant[1] ? p1.digit : p0.digit;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (!acc_err && !lat_we) ? dm_dout : 32'h0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dm_we        = 1'b0;
        p0.req_ready = 1'b0;
        p1.req_ready = 1'b0;
        p0.rsp_valid = 1'b0;
        p1.rsp_valid = 1'b0;
        p0.rsp_err   = 1'b0;
        p1.rsp_err   = 1'b0;
        p0.rsp_rdata = 32'h0;
        p1.rsp_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                // Gated by rstn so every output reads 0 while reset is held.
                p0.req_ready = grant[0] && rstn;
                p1.req_ready = grant[1] && rstn;
                if (take) state_d = ACCESS;
            end
            ACCESS: begin
                dm_we   = lat_we && !acc_err;
                state_d = RESP;
            end
            RESP: begin
                if (lat_port) begin
                    p1.rsp_valid = 1'b1;
                    p1.rsp_err   = acc_err;
                    p1.rsp_rdata = rdata_q;
                end else begin
                    p0.rsp_valid = 1'b1;
                    p0.rsp_err   = acc_err;
                    p0.rsp_rdata = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
